// File: rtl/motor_json_framer_if.sv
// Command/byte-stream bundle for motor_json_framer.
// Handshake rule (both channels): a transfer happens on the rising clk edge where valid && ready are both high;
// the source holds its payload and valid stable until that edge, and ready may depend on nothing but the sink's state.
interface motor_json_framer_if #(
  parameter int SPD_W = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic signed [SPD_W-1:0] spd_l;
  logic signed [SPD_W-1:0] spd_r;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    busy;
  logic                    frame_done;

  modport master (
    output cmd_valid, spd_l, spd_r, tx_ready,
    input  cmd_ready, tx_data, tx_valid, busy, frame_done
  );

  modport slave (
    input  cmd_valid, spd_l, spd_r, tx_ready,
    output cmd_ready, tx_data, tx_valid, busy, frame_done
  );
endinterface

// File: rtl/motor_json_framer.sv
// Renders clamped signed wheel speeds as {"T":1,"L":<v>,"R":<v>}\n and streams it byte by byte.
// Optional idle heartbeat resend is compiled in with `define MOTOR_HEARTBEAT_EN.
module motor_json_framer #(
  parameter int          SPD_W       = 8,
  parameter int          FRAC_DIGITS = 1,
  parameter int unsigned HB_CYCLES   = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  motor_json_framer_if.slave bus,
  output logic [1:0]         o_state
);
  localparam int SCALE   = (FRAC_DIGITS == 2) ? 100 : 10;
  localparam int VAL_LEN = 2 + FRAC_DIGITS;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LATCH = 2'd1, S_SEND = 2'd2} state_t;

  typedef struct packed {
    logic       neg;
    logic       int_d;
    logic [3:0] d0;
    logic [3:0] d1;
  } val_t;

  state_t           r_state, w_next_state;
  logic [SPD_W-1:0] r_spd_l, r_spd_r;
  val_t             r_val_l, r_val_r;
  logic [5:0]       r_len, r_idx;
  logic             r_frame_done;
  logic             w_accept, w_hs, w_last, w_hb_fire;
  logic [7:0]       w_byte;

  function automatic val_t conv(input logic signed [SPD_W-1:0] v);
    int   c, mag, frac, q, r;
    val_t o;
    c = int'(v);
    if (c > SCALE) c = SCALE;
    else if (c < -SCALE) c = -SCALE;
    mag     = (c < 0) ? -c : c;
    o.neg   = (c < 0);
    o.int_d = (mag >= SCALE);
    frac    = mag % SCALE;
    q       = (FRAC_DIGITS == 2) ? frac / 10 : frac;
    r       = frac % 10;
    o.d0    = 4'(q);
    o.d1    = 4'(r);
    return o;
  endfunction

  function automatic logic [7:0] val_char(input val_t v, input int p);
    int q;
    if (v.neg && p == 0) return 8'h2D;
    q = p - (v.neg ? 1 : 0);
    case (q)
      0:       return 8'h30 + {7'd0, v.int_d};
      1:       return 8'h2E;
      2:       return 8'h30 + {4'd0, v.d0};
      default: return 8'h30 + {4'd0, v.d1};
    endcase
  endfunction

  function automatic logic [7:0] pre_char(input int i);
    case (i)
      0:             return 8'h7B;
      2:             return 8'h54;
      4, 10:         return 8'h3A;
      5:             return 8'h31;
      6:             return 8'h2C;
      8:             return 8'h4C;
      default:       return 8'h22;
    endcase
  endfunction

  function automatic logic [7:0] mid_char(input int i);
    case (i)
      0:       return 8'h2C;
      2:       return 8'h52;
      4:       return 8'h3A;
      default: return 8'h22;
    endcase
  endfunction

  // Frame layout: 11-byte prefix, Lval, 5-byte ",\"R\":", Rval, '}', '\n'.
  function automatic logic [7:0] byte_at(input logic [5:0] idx, input val_t vl, input val_t vr);
    int i, lv, rv;
    i  = int'(idx);
    lv = VAL_LEN + (vl.neg ? 1 : 0);
    rv = VAL_LEN + (vr.neg ? 1 : 0);
    if (i < 11)             return pre_char(i);
    if (i < 11 + lv)        return val_char(vl, i - 11);
    if (i < 16 + lv)        return mid_char(i - 11 - lv);
    if (i < 16 + lv + rv)   return val_char(vr, i - 16 - lv);
    if (i == 16 + lv + rv)  return 8'h7D;
    return 8'h0A;
  endfunction

  assign w_accept = bus.cmd_valid && bus.cmd_ready;
  assign w_hs     = (r_state == S_SEND) && bus.tx_ready;
  assign w_last   = (r_idx == r_len - 6'd1);
  assign w_byte   = byte_at(r_idx, r_val_l, r_val_r);

`ifdef MOTOR_HEARTBEAT_EN
  logic [31:0] r_idle_cnt;

  // A same-cycle cmd_valid always wins over the heartbeat.
  assign w_hb_fire = (r_state == S_IDLE) && !bus.cmd_valid && (r_idle_cnt == HB_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             r_idle_cnt <= '0;
    else if (r_state != S_IDLE || w_accept || w_hb_fire) r_idle_cnt <= '0;
    else                                                 r_idle_cnt <= r_idle_cnt + 32'd1;
  end
`else
  assign w_hb_fire = 1'b0 & (HB_CYCLES == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept || w_hb_fire) w_next_state = S_LATCH;
      S_LATCH: w_next_state = S_SEND;
      S_SEND:  if (w_hs && w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // frame_done lands on the first IDLE cycle; commands wait one more cycle.
  always_comb begin
    bus.cmd_ready  = (r_state == S_IDLE) && !r_frame_done;
    bus.tx_valid   = (r_state == S_SEND);
    bus.tx_data    = (r_state == S_SEND) ? w_byte : 8'h00;
    bus.busy       = (r_state != S_IDLE);
    bus.frame_done = r_frame_done;
    o_state        = r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spd_l      <= '0;
      r_spd_r      <= '0;
      r_val_l      <= '0;
      r_val_r      <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_hs && w_last;
      if (w_accept) begin
        r_spd_l <= bus.spd_l;
        r_spd_r <= bus.spd_r;
      end
      if (r_state == S_LATCH) begin
        r_val_l <= conv(r_spd_l);
        r_val_r <= conv(r_spd_r);
        r_len   <= 6'(18 + 2 * VAL_LEN) + {5'd0, conv(r_spd_l).neg} + {5'd0, conv(r_spd_r).neg};
        r_idx   <= '0;
      end else if (w_hs) begin
        r_idx <= r_idx + 6'd1;
      end
    end
  end
endmodule
